// File: rtl/clock_div_multi_if.sv
// clock_div_multi_if: control/status bundle for the multi-channel clock divider.
// Optional macro CLKDIV_SYNC_EN adds the sync_i phase-align strobe.
interface clock_div_multi_if #(
  parameter int NCH = 2,
  parameter int DW  = 8
);
  logic [NCH-1:0]    en_i;
  logic [NCH*DW-1:0] div_i;
`ifdef CLKDIV_SYNC_EN
  logic              sync_i;
`endif
  logic [NCH-1:0]    clk_o;
  logic [NCH-1:0]    tick_o;
  logic [NCH-1:0]    busy_o;

  modport master (
    output en_i,
    output div_i,
`ifdef CLKDIV_SYNC_EN
    output sync_i,
`endif
    input  clk_o,
    input  tick_o,
    input  busy_o
  );

  modport slave (
    input  en_i,
    input  div_i,
`ifdef CLKDIV_SYNC_EN
    input  sync_i,
`endif
    output clk_o,
    output tick_o,
    output busy_o
  );
endinterface

// File: rtl/clock_div_multi.sv
// clock_div_multi: NCH independent runtime-programmable integer clock dividers.
// Each channel produces a registered near-50% divided level and a one-cycle
// tick at each period start. Divisor and enable are only sampled at period
// boundaries so stopping or retuning never truncates a phase.
// Optional macro CLKDIV_SYNC_EN: sync_i forces every running channel to a
// period boundary (phase alignment across channels).
module clock_div_multi #(
  parameter int NCH = 2,
  parameter int DW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  clock_div_multi_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [NCH-1:0] state_q, state_d;
  logic [DW-1:0]  cnt_q [NCH];
  logic [DW-1:0]  cnt_d [NCH];
  logic [DW-1:0]  na_q  [NCH];
  logic [DW-1:0]  na_d  [NCH];
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [DW-1:0]  div_w [NCH];
  logic           sync_w;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_div
    assign div_w[g] = bus.div_i[g*DW +: DW];
  end

`ifdef CLKDIV_SYNC_EN
  assign sync_w = bus.sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // Next-state: start/reload at IDLE or period boundary, otherwise count within the period
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      na_d[k]    = na_q[k];
      clk_d[k]   = 1'b0;
      tick_d[k]  = 1'b0;
      busy_d[k]  = 1'b0;
      if ((state_q[k] == S_IDLE) ||
          (cnt_q[k] == na_q[k] - 1'b1) || sync_w) begin
        if (bus.en_i[k] && (div_w[k] != '0)) begin
          state_d[k] = S_RUN;
          na_d[k]    = div_w[k];
          cnt_d[k]   = '0;
          tick_d[k]  = 1'b1;
          busy_d[k]  = 1'b1;
          clk_d[k]   = ((div_w[k] >> 1) != '0);
        end else begin
          state_d[k] = S_IDLE;
          na_d[k]    = '0;
          cnt_d[k]   = '0;
        end
      end else begin
        cnt_d[k]  = cnt_q[k] + 1'b1;
        busy_d[k] = 1'b1;
        // Compare one bit wider so cnt+1 cannot wrap
        clk_d[k]  = (({1'b0, cnt_q[k]} + {{DW{1'b0}}, 1'b1}) < {1'b0, (na_q[k] >> 1)});
      end
    end
  end

  // State and output registers; reset returns every channel to IDLE immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= {NCH{S_IDLE}};
      clk_q   <= '0;
      tick_q  <= '0;
      busy_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
        na_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
        na_q[k]  <= na_d[k];
      end
    end
  end

  assign bus.clk_o  = clk_q;
  assign bus.tick_o = tick_q;
  assign bus.busy_o = busy_q;
endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed + randomized stimulus for clock_div_multi,
// checked against a period-schedule reference model.
module tb_clock_div_multi;
  localparam int NCH = 2;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0]    en_v  = '0;
  logic [NCH*DW-1:0] div_v = '0;
  logic              sync_v = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  clock_div_multi_if #(.NCH(NCH), .DW(DW)) bus ();
  assign bus.en_i  = en_v;
  assign bus.div_i = div_v;
`ifdef CLKDIV_SYNC_EN
  assign bus.sync_i = sync_v;
`endif

  clock_div_multi #(.NCH(NCH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each started period is a list of N samples {tick,clk};
  // inputs are only consulted once the list for the current period runs out.
  logic [1:0]     sched [NCH][$];
  logic [NCH-1:0] exp_clk = '0, exp_tick = '0, exp_busy = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int n;
      logic [1:0] e;
      if (rst) begin
        sched[c].delete();
      end else begin
`ifdef CLKDIV_SYNC_EN
        if (sync_v && exp_busy[c]) sched[c].delete();
`endif
        n = int'(div_v[c*DW +: DW]);
        if (sched[c].size() == 0 && en_v[c] && n != 0)
          for (int i = 0; i < n; i++) sched[c].push_back({(i == 0), (i < n / 2)});
      end
      if (sched[c].size() > 0) begin
        e = sched[c].pop_front();
        exp_tick[c] = e[1];
        exp_clk[c]  = e[0];
        exp_busy[c] = 1'b1;
      end else begin
        exp_tick[c] = 1'b0;
        exp_clk[c]  = 1'b0;
        exp_busy[c] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("clk_o",  32'(bus.clk_o),  32'(exp_clk));
    chk("tick_o", 32'(bus.tick_o), 32'(exp_tick));
    chk("busy_o", 32'(bus.busy_o), 32'(exp_busy));
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      sync_v = 1'b0;
    end
  endtask

  task automatic set_div(input int c, input int n);
    div_v[c*DW +: DW] = DW'(n);
  endtask

  // Asynchronous reset placed mid-cycle; outputs must clear with no clock edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk",  32'(bus.clk_o),  32'd0);
    chk("arst_tick", 32'(bus.tick_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    for (int c = 0; c < NCH; c++) sched[c].delete();
    exp_clk = '0; exp_tick = '0; exp_busy = '0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    rst = 1'b0;
    step(1);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);

    // Divide by 4, then change to 6 at cnt=1
    set_div(0, 4); en_v[0] = 1'b1;
    step(1);
    chk("first_tick", 32'(bus.tick_o[0]), 32'd1);
    step(1);
    set_div(0, 6);
    step(16);
    // Drop enable at cnt=1 of a 6-period, then re-enable
    while (!bus.tick_o[0]) step(1);
    step(1);
    en_v[0] = 1'b0;
    step(4);
    chk("stop_busy_last", 32'(bus.busy_o[0]), 32'd1);
    step(1);
    chk("stop_busy", 32'(bus.busy_o[0]), 32'd0);
    chk("stop_clk",  32'(bus.clk_o[0]),  32'd0);
    step(2);
    en_v[0] = 1'b1;
    step(7);

    // Divide by 3, 1 and 0 (0 must leave the channel idle)
    set_div(0, 3); step(9);
    set_div(0, 1); step(6);
    en_v[0] = 1'b0; step(2);
    set_div(0, 0); en_v[0] = 1'b1; step(3);
    chk("div0_idle", 32'(bus.busy_o[0]), 32'd0);

    // Two channels at 4 and 6, with a sync pulse
    set_div(0, 4); set_div(1, 6); en_v = '1;
    step(5);
    sync_v = 1'b1;
    step(14);

    // Async reset mid-run then clean restart
    while (!bus.clk_o[1]) step(1);
    async_reset();
    step(10);

    // Randomized stimulus
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0) en_v[c] = ~en_v[c];
        if ($urandom_range(0, 9) == 0) set_div(c, int'($urandom_range(0, 9)));
        if ($urandom_range(0, 199) == 0) set_div(c, int'($urandom_range(10, 40)));
      end
      if ($urandom_range(0, 39) == 0) sync_v = 1'b1;
      if ($urandom_range(0, 499) == 0) async_reset();
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised, multi-channel, runtime-programmable integer clock divider; generalises the fixed ÷2/÷3 divider to NCH independent channels.
- Each channel has a DW-bit divisor, an enable, glitch-free start/stop, and divisor reload only at period boundaries.
- Outputs per channel: near-50% divided clock level (clk_o) plus a one-cycle clock-enable pulse (tick_o) for downstream logic on the same clk.
- Used to derive write/read side rates for the FIFO and peripheral blocks from the single system clock.

Parameters:
- NCH, 2, number of independent divider channels (>=1).
- DW, 8, divisor width per channel; divisor range 0..2^DW-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_i  input  NCH  per-channel run request.
- div_i  input  NCH*DW  per-channel divisor N; channel k uses bits [k*DW +: DW].
- sync_i  input  1  phase-align strobe; present only with CLKDIV_SYNC_EN.
- clk_o  output  NCH  divided clock level, registered.
- tick_o  output  NCH  one-cycle pulse at the start of each period, registered.
- busy_o  output  NCH  channel in RUN state, registered.

Behaviour:
- Reset (async, rst=1): every channel IDLE, cnt=0, active divisor NA=0; clk_o=0, tick_o=0, busy_o=0.
- Per channel: FSM IDLE/RUN, counter cnt (DW bits), active divisor NA, high count H = NA>>1.
- All outputs are registered. Values below are those present the cycle after the event.
- IDLE, sampling en_i=1 and div_i!=0:
  - NA<=div_i, state RUN, cnt=0, tick_o=1, busy_o=1.
  - clk_o = (0 < H).
- IDLE, otherwise: remain IDLE, outputs 0.
- RUN, cnt!=NA-1:
  - cnt<=cnt+1.
  - clk_o = (cnt+1 < H).
  - tick_o=0.
- RUN, boundary (cnt==NA-1):
  - Sample div_i and en_i.
  - If en_i=0 or div_i==0: IDLE, all outputs 0.
  - Else: NA<=div_i, cnt=0, tick_o=1, clk_o=(0 < new H).
- Resulting waveforms:
  - N even: clk_o high N/2, low N/2.
  - N odd: high floor(N/2), low ceil(N/2).
  - N=1: clk_o constant 0, tick_o constant 1.
  - tick_o coincides with each rising edge of clk_o (N>=2).
- en_i deassert mid-period: current period runs to completion and clk_o ends low. No truncated high pulse, so stop is glitch-free.
- div_i change mid-period: ignored until the boundary. The new period uses the new divisor; the current period never shortens.
- Channels are fully independent; one channel's events never affect another.
- Reset asserted mid-operation: immediate return to reset values, no completion of the current period.
- First tick after enable: 1 cycle latency from the en_i sample edge.

Optional Feature:
- Macro CLKDIV_SYNC_EN.
- Defined:
  - sync_i port exists.
  - When sync_i=1, every channel in RUN behaves as at a boundary regardless of cnt: samples en_i/div_i, restarts at cnt=0, tick_o=1.
  - IDLE channels follow normal IDLE rules.
  - sync_i may truncate the current period; this is the only case clk_o may have a shortened high or low phase.
- Not defined: port and logic absent; boundaries occur only at cnt==NA-1.

Test Plan:
- Ch0 div_i=4, en_i=1 held -> clk_o repeats 1,1,0,0; tick_o on every 4th cycle; first tick 1 cycle after en_i sampled.
- Ch0 div_i=3 -> clk_o repeats 1,0,0 (high 1, low 2); div_i=1 -> tick_o constant 1, clk_o constant 0; div_i=0 with en_i=1 -> stays IDLE, busy_o=0.
- Running div=4, change div_i to 6 at cnt=1 -> the remaining 4-cycle period completes, then 6-cycle periods with 3 high/3 low.
- Running div=6, drop en_i at cnt=1 -> 4 more cycles, then busy_o=0 with clk_o=0 and no glitch; re-assert en_i -> restart at cnt=0 with tick.
- Ch0 div=4, ch1 div=6, pulse sync_i (CLKDIV_SYNC_EN) -> both tick_o=1 the next cycle; they coincide again after 12 cycles.
- rst=1 asynchronously mid-high phase -> clk_o, tick_o, busy_o=0 immediately (no clock edge needed); after release with en_i=1, the channel restarts cleanly.
